aes_key_expand_seq: RTL and testbench

Sequential AES key-schedule generator that feeds the round-key array consumed by the pipelined cipher and inverse-cipher datapaths. It accepts a cipher key through a valid/ready handshake and produces one schedule word per clock. It holds the complete `rkey[4*(Nr+1)]` array stable and flags it with `rkey_valid` until a new key is accepted. It replaces a fully combinational expansion, trading about 4·Nr cycles of latency for one SubWord S-box instance.

---
 rtl/aes_key_expand_seq.sv | 125 ++++++++++++
 tb/tb_aes_key_expand_seq.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_expand_seq.sv
// Sequential AES key schedule: one expanded word per clock, one S-box row.
// Holds the full round-key array stable behind rkey_valid until re-keyed.
module aes_key_expand_seq #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  output logic              key_ready,
  input  logic [32*Nk-1:0]  key,
  output logic [31:0]       rkey [4*(Nr+1)],
  output logic              rkey_valid,
  output logic              busy
);

  localparam int NW = 4 * (Nr + 1);
  localparam logic [5:0] LAST = 6'(NW - 1);
  localparam logic [2:0] PMAX = 3'(Nk - 1);

  if (!(Nk == 4 || Nk == 6 || Nk == 8)) begin : g_bad_nk
    $error("aes_key_expand_seq: Nk must be 4, 6 or 8");
  end

  // Forward S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[{~x, 3'b111} -: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_e;

  state_e      state_q;
  logic [5:0]  i_q;
  logic [2:0]  p_q;
  logic [7:0]  rcon_q, rcon_d;
  logic [31:0] w_q [NW];
  logic        valid_q, ready_q, busy_q;

  logic [5:0]  i_prev, i_far;
  logic [31:0] prev, far, sub_in, sub, t, w_d;

  always_comb begin
    i_prev = i_q - 6'd1;
    i_far  = i_q - 6'(Nk);
    prev   = w_q[i_prev];
    far    = w_q[i_far];
    sub_in = (p_q == 3'd0) ? {prev[7:0], prev[31:8]} : prev;
    sub    = {sbox(sub_in[31:24]), sbox(sub_in[23:16]),
              sbox(sub_in[15:8]), sbox(sub_in[7:0])};
    if (p_q == 3'd0)
      t = sub ^ {24'h0, rcon_q};
    else if (Nk == 8 && p_q == 3'd4)
      t = sub;
    else
      t = prev;
    w_d    = far ^ t;
    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      i_q     <= '0;
      p_q     <= '0;
      rcon_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      for (int j = 0; j < NW; j++) w_q[j] <= '0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (key_valid) begin
            for (int j = 0; j < Nk; j++) w_q[j] <= key[32*j +: 32];
            i_q     <= 6'(Nk);
            p_q     <= '0;
            rcon_q  <= 8'h01;
            valid_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= EXPAND;
          end
        end
        EXPAND: begin
          w_q[i_q] <= w_d;
          i_q      <= i_q + 6'd1;
          p_q      <= (p_q == PMAX) ? 3'd0 : p_q + 3'd1;
          if (p_q == 3'd0) rcon_q <= rcon_d;
          if (i_q == LAST) begin
            valid_q <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rkey       = w_q;
  assign rkey_valid = valid_q;
  assign key_ready  = ready_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
// Bench for aes_key_expand_seq: Nk=4/6/8 instances vs a GF(2^8) schedule model.
// Model builds the S-box from field inversion, independent of the RTL table.
module tb_aes_key_expand_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        kv [3];
  logic        kr [3];
  logic        vl [3];
  logic        bz [3];
  logic [255:0] kin [3];
  logic [31:0] rk4 [44];
  logic [31:0] rk6 [52];
  logic [31:0] rk8 [60];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_key_expand_seq #(.Nk(4)) u4 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[0]), .key_ready(kr[0]),
    .key(kin[0][127:0]), .rkey(rk4), .rkey_valid(vl[0]), .busy(bz[0]));
  aes_key_expand_seq #(.Nk(6)) u6 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[1]), .key_ready(kr[1]),
    .key(kin[1][191:0]), .rkey(rk6), .rkey_valid(vl[1]), .busy(bz[1]));
  aes_key_expand_seq #(.Nk(8)) u8 (
    .clk(clk), .rst_n(rst_n), .key_valid(kv[2]), .key_ready(kr[2]),
    .key(kin[2]), .rkey(rk8), .rkey_valid(vl[2]), .busy(bz[2]));

  function automatic int nk_of(int n);
    return 4 + 2 * n;
  endfunction

  function automatic int nw_of(int n);
    return 4 * (nk_of(n) + 7);
  endfunction

  function automatic logic [31:0] dw(int n, int j);
    case (n)
      0: return rk4[j];
      1: return rk6[j];
      default: return rk8[j];
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] r = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) r = r ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(logic [7:0] x);
    logic [7:0] inv = 8'h01;
    logic [7:0] s;
    for (int k = 0; k < 254; k++) inv = gmul(inv, x);
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
            ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sbox_m(w[31:24]), sbox_m(w[23:16]),
            sbox_m(w[15:8]), sbox_m(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon_m(int r);
    logic [7:0] v = 8'h01;
    for (int k = 1; k < r; k++) v = gmul(v, 8'h02);
    return v;
  endfunction

  logic [31:0] m_w [3][60];
  int          m_rem [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic        m_known [3];

  function automatic void model_expand(int n, logic [255:0] k);
    int nk = nk_of(n);
    logic [31:0] t;
    for (int j = 0; j < nk; j++) m_w[n][j] = k[32*j +: 32];
    for (int i = nk; i < nw_of(n); i++) begin
      t = m_w[n][i-1];
      if (i % nk == 0)
        t = subw({t[7:0], t[31:8]}) ^ {24'h0, rcon_m(i / nk)};
      else if (nk == 8 && i % nk == 4)
        t = subw(t);
      m_w[n][i] = m_w[n][i-nk] ^ t;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < 3; n++) begin
        m_rem[n] = 0; m_valid[n] = 0; m_ready[n] = 1; m_known[n] = 1;
        for (int j = 0; j < 60; j++) m_w[n][j] = '0;
      end
    end else begin
      for (int n = 0; n < 3; n++) begin
        if (m_rem[n] > 0) begin
          m_rem[n]--;
          if (m_rem[n] == 0) begin
            m_valid[n] = 1; m_ready[n] = 1; m_known[n] = 1;
          end
        end else if (kv[n] && m_ready[n]) begin
          model_expand(n, kin[n]);
          m_rem[n] = 4 * nw_of(n) / 4 - nk_of(n);
          m_valid[n] = 0; m_ready[n] = 0; m_known[n] = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    for (int n = 0; n < 3; n++) begin
      checks++;
      if (vl[n] !== m_valid[n] || kr[n] !== m_ready[n] || bz[n] !== !m_ready[n]) begin
        errors++;
        $display("FAIL flags inst%0d: got v/r/b %b%b%b want %b%b%b", n,
                 vl[n], kr[n], bz[n], m_valid[n], m_ready[n], !m_ready[n]);
      end
      if (m_known[n]) begin
        int bad = -1;
        checks++;
        for (int j = nw_of(n) - 1; j >= 0; j--)
          if (dw(n, j) !== m_w[n][j]) bad = j;
        if (bad >= 0) begin
          errors++;
          $display("FAIL words inst%0d w[%0d]: got %h want %h", n, bad,
                   dw(n, bad), m_w[n][bad]);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  function automatic logic [255:0] fips(logic [255:0] f, int nk);
    logic [255:0] pk = '0;
    for (int b = 0; b < 4 * nk; b++) pk[8*b +: 8] = f[8*(4*nk-1-b) +: 8];
    return pk;
  endfunction

  function automatic logic [255:0] rnd_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  task automatic accept(int n, logic [255:0] k);
    kin[n] = k;
    kv[n]  = 1'b1;
    @(posedge clk); #1;
    kv[n]  = 1'b0;
  endtask

  task automatic wait_done(int n, int want_lat, string name);
    int lat = 0;
    while (!vl[n] && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(name, 32'(lat), 32'(want_lat));
  endtask

  task automatic check_reset_now(string name);
    for (int n = 0; n < 3; n++) begin
      int nz = 0;
      for (int j = 0; j < nw_of(n); j++) if (dw(n, j) !== '0) nz++;
      chk({name, "_zero"}, 32'(nz), 32'd0);
      chk({name, "_flags"}, {29'd0, vl[n], kr[n], bz[n]}, 32'b010);
    end
  endtask

  logic [255:0] ka1, ka2, ka3, kb, kc;
  logic [31:0]  snap [60];
  int           lat;

  initial begin
    ka1 = fips(256'h2b7e151628aed2a6abf7158809cf4f3c, 4);
    ka2 = fips(256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 6);
    ka3 = fips(256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, 8);
    rst_n = 1'b0;
    for (int n = 0; n < 3; n++) begin kv[n] = 1'b0; kin[n] = '0; end
    repeat (2) @(posedge clk);
    #1;
    check_reset_now("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    chk("a1_key_word0", ka1[31:0], 32'h16157e2b);
    accept(0, ka1);
    wait_done(0, 40, "a1_latency");
    chk("a1_w4", rk4[4], 32'h17fefaa0);
    chk("a1_w43", rk4[43], 32'ha60c63b6);
    chk("model_a1_w43", m_w[0][43], 32'ha60c63b6);

    accept(1, ka2);
    wait_done(1, 46, "a2_latency");
    chk("a2_w51", rk6[51], 32'h02220001);

    accept(2, ka3);
    wait_done(2, 52, "a3_latency");
    chk("a3_w59", rk8[59], 32'h1e636c70);
    chk("model_a3_w59", m_w[2][59], 32'h1e636c70);

    // hold a competing key on the port for the whole expansion
    kb = rnd_key();
    accept(0, kb);
    kin[0] = rnd_key();
    kv[0]  = 1'b1;
    lat = 0;
    while (!vl[0] && lat < 300) begin
      chk("hold_ready_low", {31'd0, kr[0]}, 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    kv[0] = 1'b0;
    chk("hold_latency", 32'(lat), 32'd40);
    chk("hold_w43", rk4[43], m_w[0][43]);

    kc = rnd_key();
    accept(0, kc);
    chk("rekey_valid_drop", {31'd0, vl[0]}, 32'd0);
    wait_done(0, 40, "rekey_latency");

    // randomized keys on all widths with random idle gaps
    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 3; n++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        accept(n, rnd_key());
        wait_done(n, 28 + 3 * nk_of(n), "rand_latency");
      end
    end

    // asynchronous reset in the middle of an expansion
    accept(0, ka1);
    repeat (20) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_now("mid_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    accept(0, ka1);
    wait_done(0, 40, "post_reset_latency");
    chk("post_reset_w4", rk4[4], 32'h17fefaa0);
    chk("post_reset_w43", rk4[43], 32'ha60c63b6);

    // stability in DONE
    for (int j = 0; j < 44; j++) snap[j] = rk4[j];
    repeat (100) @(posedge clk);
    #1;
    begin
      int diff = 0;
      for (int j = 0; j < 44; j++) if (rk4[j] !== snap[j]) diff++;
      chk("stable_words", 32'(diff), 32'd0);
    end
    chk("stable_busy", {31'd0, bz[0]}, 32'd0);
    chk("stable_valid", {31'd0, vl[0]}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
